// File: rtl/gpio_core_pkg.sv
// ============================================================================
// gpio_core_pkg : shared encodings and output-word packing for gpio_isqrt_core
// rev 1.0
// ============================================================================
`default_nettype none

package gpio_core_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int CNT_W      = 4;

  // Bit positions inside the two GPIO read-back words
  localparam int A_BUSY_BIT = 15;
  localparam int A_DONE_BIT = 14;
  localparam int A_ROOT_MSB = 7;
  localparam int A_ROOT_LSB = 0;
  localparam int B_CNT_MSB  = 15;
  localparam int B_CNT_LSB  = 12;
  localparam int B_REM_MSB  = 8;
  localparam int B_REM_LSB  = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [15:0] pack_out_a(input logic       busy,
                                             input logic       done,
                                             input logic [7:0] root);
    logic [15:0] v;
    v = '0;
    v[A_BUSY_BIT]            = busy;
    v[A_DONE_BIT]            = done;
    v[A_ROOT_MSB:A_ROOT_LSB] = root;
    return v;
  endfunction

  function automatic logic [15:0] pack_out_b(input logic [CNT_W-1:0] cnt,
                                             input logic [8:0]       rem);
    logic [15:0] v;
    v = '0;
    v[B_CNT_MSB:B_CNT_LSB] = cnt;
    v[B_REM_MSB:B_REM_LSB] = rem;
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/isqrt_step.sv
// ============================================================================
// isqrt_step : one digit-pair iteration of the restoring integer square root
// rev 1.0
// ============================================================================
`default_nettype none

module isqrt_step #(
  parameter int ROOT_W = 8
) (
  input  logic [ROOT_W-1:0] q_i,
  input  logic [ROOT_W+1:0] r_i,
  input  logic [1:0]        pair_i,
  output logic [ROOT_W-1:0] q_next_o,
  output logic [ROOT_W+1:0] r_next_o
);

  logic [ROOT_W+3:0] w_cat;
  logic [ROOT_W+1:0] w_trial;
  logic [ROOT_W+1:0] w_diff;
  logic              w_fits;

  assign w_cat   = {r_i, pair_i};
  assign w_trial = {q_i, 2'b01};
  assign w_fits  = (w_cat >= {2'b00, w_trial});
  // The true difference never exceeds 2*root, so the truncated subtract is exact
  assign w_diff  = w_cat[ROOT_W+1:0] - w_trial;

  assign q_next_o = {q_i[ROOT_W-2:0], w_fits};
  assign r_next_o = w_fits ? w_diff : {r_i[ROOT_W-1:0], pair_i};

endmodule

`default_nettype wire

// File: rtl/gpio_isqrt_core.sv
// ============================================================================
// gpio_isqrt_core : GPIO-attached iterative square root, one root bit per clock
// rev 1.0
// ============================================================================
`default_nettype none

module gpio_isqrt_core
  import gpio_core_pkg::*;
#(
  parameter int DATA_W            = DATA_W_DEF,
  parameter bit RESTART_ON_CHANGE = 1'b1
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic [15:0] mod_in,
  output logic [15:0] mod_out_a,
  output logic [15:0] mod_out_b
);

  localparam int ROOT_W = DATA_W / 2;
  localparam int ITERS  = DATA_W / 2;
  localparam int ITER_W = $clog2(ITERS);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   op_q,    op_d;
  logic [ITER_W-1:0]   iter_q,  iter_d;
  logic [ROOT_W-1:0]   q_q,     q_d;
  logic [ROOT_W+1:0]   r_q,     r_d;
  logic [ROOT_W-1:0]   root_q,  root_d;
  logic [ROOT_W:0]     rem_q,   rem_d;
  logic [CNT_W-1:0]    cnt_q,   cnt_d;
  logic                busy_q,  busy_d;
  logic                done_q,  done_d;

  logic [1:0]          w_pair;
  logic [ROOT_W-1:0]   w_q_next;
  logic [ROOT_W+1:0]   w_r_next;
  logic                w_changed;
  logic                w_last;
  logic                w_start;

  assign w_changed = (mod_in != op_q);
  assign w_last    = (iter_q == ITER_W'(ITERS - 1));

  // Radicand pairs are consumed MSB first
  always_comb begin
    w_pair = '0;
    for (int i = 0; i < ITERS; i++) begin
      if (iter_q == ITER_W'(i)) begin
        w_pair = op_q[DATA_W-1-2*i -: 2];
      end
    end
  end

  isqrt_step #(
    .ROOT_W (ROOT_W)
  ) u_step (
    .q_i      (q_q),
    .r_i      (r_q),
    .pair_i   (w_pair),
    .q_next_o (w_q_next),
    .r_next_o (w_r_next)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    iter_d  = iter_q;
    q_d     = q_q;
    r_d     = r_q;
    root_d  = root_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    w_start = 1'b0;

    case (state_q)
      ST_IDLE: begin
        w_start = 1'b1;
      end
      ST_CALC: begin
        // An abort on the final iteration suppresses that run's publish
        if (RESTART_ON_CHANGE && w_changed) begin
          w_start = 1'b1;
        end else begin
          q_d    = w_q_next;
          r_d    = w_r_next;
          iter_d = iter_q + ITER_W'(1);
          if (w_last) begin
            root_d  = w_q_next;
            rem_d   = w_r_next[ROOT_W:0];
            cnt_d   = cnt_q + CNT_W'(1);
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        w_start = w_changed;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (w_start) begin
      op_d    = mod_in;
      iter_d  = '0;
      q_d     = '0;
      r_d     = '0;
      busy_d  = 1'b1;
      done_d  = 1'b0;
      state_d = ST_CALC;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      iter_q  <= '0;
      q_q     <= '0;
      r_q     <= '0;
      root_q  <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      iter_q  <= iter_d;
      q_q     <= q_d;
      r_q     <= r_d;
      root_q  <= root_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign mod_out_a = pack_out_a(busy_q, done_q, root_q);
  assign mod_out_b = pack_out_b(cnt_q, rem_q);

endmodule

`default_nettype wire

// File: tb/tb_gpio_isqrt_core.sv
// ============================================================================
// tb_gpio_isqrt_core : scoreboard bench for gpio_isqrt_core
// rev 1.0
// ============================================================================
`default_nettype none

module tb_gpio_isqrt_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] mod_in;
  logic [15:0] out_a, out_b;
  logic        rst0;
  logic [15:0] mod_in0;
  logic [15:0] out_a0, out_b0;

  always #5 clk = ~clk;

  gpio_isqrt_core #(
    .DATA_W            (16),
    .RESTART_ON_CHANGE (1'b1)
  ) u_dut (
    .ACLK      (clk),
    .ARESET    (rst),
    .mod_in    (mod_in),
    .mod_out_a (out_a),
    .mod_out_b (out_b)
  );

  gpio_isqrt_core #(
    .DATA_W            (16),
    .RESTART_ON_CHANGE (1'b0)
  ) u_dut_norestart (
    .ACLK      (clk),
    .ARESET    (rst0),
    .mod_in    (mod_in0),
    .mod_out_a (out_a0),
    .mod_out_b (out_b0)
  );

  typedef struct {
    logic [15:0] v;
    logic [15:0] a;
    logic [15:0] b;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad   = 0;
  int          model_cnt;
  logic        prev_done = 1'b0;
  logic [15:0] prev_v;

  function automatic int ref_root(input int v);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Holding a value for 9+ sampled edges lets it complete; shorter holds are aborted
  task automatic apply(input logic [15:0] v, input int n);
    exp_t e;
    int   r;
    mod_in = v;
    prev_v = v;
    if (n >= 9) begin
      r         = ref_root(int'(v));
      model_cnt = (model_cnt + 1) % 16;
      e.v       = v;
      e.a       = 16'h4000 | 16'(r);
      e.b       = 16'(model_cnt << 12) | 16'(int'(v) - r * r);
      exp_q.push_back(e);
    end
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_done0(input logic level, input int limit, input string name);
    int k;
    k = 0;
    while (out_a0[14] !== level && k < limit) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (out_a0[14] !== level) begin
      bad++;
      $display("FAIL %s: done got %b want %b within %0d cycles", name, out_a0[14], level, limit);
    end
  endtask

  function automatic logic [15:0] pick_value(input logic [15:0] avoid);
    logic [15:0] v;
    int          k;
    v = avoid;
    while (v == avoid) begin
      k = int'($urandom_range(0, 255));
      case ($urandom_range(0, 4))
        0:       v = 16'(k * k);
        1:       v = (k == 0) ? 16'hFFFF : 16'(k * k - 1);
        2:       v = 16'h0000;
        3:       v = 16'hFFFF;
        default: v = 16'($urandom);
      endcase
    end
    return v;
  endfunction

  // Monitor: pop an expectation on every rising done and check exclusivity each cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      total++;
      if ((out_a[15] && out_a[14]) || (out_a0[15] && out_a0[14])) begin
        bad++;
        $display("FAIL busy_done_excl: a=%h a0=%h", out_a, out_a0);
      end
      if (!prev_done && out_a[14] === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got a=%h b=%h want no completion", out_a, out_b);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("out_a v=%h", e.v), out_a, e.a);
          check($sformatf("out_b v=%h", e.v), out_b, e.b);
        end
      end
      prev_done = out_a[14];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] v;
    int          n;
    int          k;

    rst       = 1'b1;
    mod_in    = 16'h0000;
    prev_v    = 16'h0000;
    rst0      = 1'b1;
    mod_in0   = 16'h0100;
    model_cnt = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_a", out_a, 16'h0000);
    check("reset_b", out_b, 16'h0000);

    rst = 1'b0;
    fork
      apply(16'h0000, 10);
      begin @(posedge clk); #1; check("busy_after_release", out_a, 16'h8000); end
    join
    fork
      apply(16'hFFFF, 10);
      begin @(posedge clk); #1; check("busy_from_done", out_a, 16'h8000); end
    join
    apply(16'd144, 10);
    fork
      apply(16'd145, 10);
      begin repeat (4) @(posedge clk); #1; check("root_held_calc", out_a, 16'h800C); end
    join

    apply(16'h0100, 4);
    fork
      apply(16'h0051, 10);
      begin repeat (5) @(posedge clk); #1; check("restart_no_publish", out_a, 16'h800C); end
    join

    apply(16'h1234, 5);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midcalc_reset_a", out_a, 16'h0000);
    check("midcalc_reset_b", out_b, 16'h0000);
    rst       = 1'b0;
    model_cnt = 0;
    apply(16'h1234, 10);

    for (int i = 0; i < 17; i++) begin
      v = pick_value(prev_v);
      apply(v, 9);
    end

    for (int i = 0; i < 30; i++) begin
      v = pick_value(prev_v);
      n = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 8)) : int'($urandom_range(9, 13));
      apply(v, n);
    end
    apply(pick_value(prev_v), 10);

    k = 0;
    while (exp_q.size() != 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL pending_results: got %0d outstanding want 0", exp_q.size());
    end

    rst0 = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    mod_in0 = 16'h0051;
    wait_done0(1'b1, 30, "norestart_first_done");
    check("norestart_first_a", out_a0, 16'h4010);
    check("norestart_first_b", out_b0, 16'h1000);
    wait_done0(1'b0, 5, "norestart_recapture");
    wait_done0(1'b1, 20, "norestart_second_done");
    check("norestart_second_a", out_a0, 16'h4009);
    check("norestart_second_b", out_b0, 16'h2000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
